multu_sequencer: RTL and testbench

- Controls the iterative 32-cycle MULTU multiplier and the HI/LO register pair in the pipelined MIPS datapath.
- Accepts a MULTU from the EX stage, then drives the multiplier through load, iterate and HI/LO-write phases.
- Stalls the pipeline on structural and data hazards against HI/LO: a second MULTU, MFHI or MFLO issued while a multiply is in flight.
- Replaces the free-running counter inside the ALU control path with an explicit FSM that can be reset and flushed.

---
 rtl/multu_sequencer.sv | 131 +++++++++++++
 tb/tb_multu_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multu_sequencer.sv
// ============================================================================
//  Module   : multu_sequencer
//  Purpose  : LOAD/RUN/WRITE sequencer for the iterative MULTU unit and HI/LO,
//             with pipeline stall generation for HI/LO hazards.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multu_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int CNT_W       = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IssueValid,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic             Flush,
   output logic             MulStart,
   output logic             MulShift,
   output logic             HiLoWrite,
   output logic [5:0]       MULTUOperation,
   output logic             Busy,
   output logic             Stall,
   output logic [CNT_W-1:0] Count
);

   localparam logic [1:0]       c_ALUOP_RTYPE = 2'b10;
   localparam logic [5:0]       c_FN_MULTU    = 6'b011001;
   localparam logic [5:0]       c_FN_MFHI     = 6'b010000;
   localparam logic [5:0]       c_FN_MFLO     = 6'b010010;
   localparam logic [5:0]       c_OP_MULTU    = 6'b011001;
   localparam logic [5:0]       c_OP_HILO     = 6'b111111;
   localparam logic [CNT_W-1:0] c_LAST        = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_next_count;
   logic             w_is_rtype;
   logic             w_is_multu;
   logic             w_is_hilo_rd;

   assign w_is_rtype   = IssueValid && (ALUOp == c_ALUOP_RTYPE);
   assign w_is_multu   = w_is_rtype && (Funct == c_FN_MULTU);
   assign w_is_hilo_rd = w_is_rtype && ((Funct == c_FN_MFHI) || (Funct == c_FN_MFLO));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
      end
   end

   // Flush only aborts before the result is committed; WRITE always completes.
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      case (r_state)
         S_IDLE: begin
            w_next_count = '0;
            if (w_is_multu && !Flush) begin
               w_next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            w_next_count = '0;
            w_next_state = Flush ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (Flush) begin
               w_next_state = S_IDLE;
               w_next_count = '0;
            end else if (r_count == c_LAST) begin
               w_next_state = S_WRITE;
               w_next_count = '0;
            end else begin
               w_next_count = r_count + c_ONE;
            end
         end
         S_WRITE: begin
            w_next_state = S_IDLE;
            w_next_count = '0;
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_count = '0;
         end
      endcase
   end

   always_comb begin
      MulStart       = 1'b0;
      MulShift       = 1'b0;
      HiLoWrite      = 1'b0;
      MULTUOperation = 6'b000000;
      case (r_state)
         S_LOAD: begin
            MulStart       = 1'b1;
            MULTUOperation = c_OP_MULTU;
         end
         S_RUN: begin
            MulShift       = 1'b1;
            MULTUOperation = c_OP_MULTU;
         end
         S_WRITE: begin
            HiLoWrite      = 1'b1;
            MULTUOperation = c_OP_HILO;
         end
         default: ;
      endcase
   end

   assign Busy  = (r_state != S_IDLE);
   assign Stall = Busy && (w_is_multu || w_is_hilo_rd);
   assign Count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multu_sequencer.sv
// ============================================================================
//  Module   : tb_multu_sequencer
//  Purpose  : Self-checking bench for multu_sequencer against a cycle-position
//             reference model of the multiply timeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multu_sequencer;

   localparam int MC = 32;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       IssueValid = 1'b0;
   logic [1:0] ALUOp = 2'b00;
   logic [5:0] Funct = 6'b000000;
   logic       Flush = 1'b0;
   logic       MulStart, MulShift, HiLoWrite, Busy, Stall;
   logic [5:0] MULTUOperation;
   logic [5:0] Count;

   int total = 0;
   int bad   = 0;
   int n_hilo = 0;
   int m_k = 0;   // model: 0 = idle, else cycle number since acceptance (1..MC+2)

   wire logic [16:0] obs = {MulStart, MulShift, HiLoWrite, MULTUOperation, Busy, Stall, Count};

   multu_sequencer #(.MULT_CYCLES(MC), .CNT_W(6)) dut (
      .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .ALUOp(ALUOp), .Funct(Funct),
      .Flush(Flush), .MulStart(MulStart), .MulShift(MulShift), .HiLoWrite(HiLoWrite),
      .MULTUOperation(MULTUOperation), .Busy(Busy), .Stall(Stall), .Count(Count)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) if (HiLoWrite === 1'b1) n_hilo++;

   function automatic bit is_mu();
      return IssueValid && ALUOp == 2'b10 && Funct == F_MULTU;
   endfunction

   function automatic bit is_rd();
      return IssueValid && ALUOp == 2'b10 && (Funct == F_MFHI || Funct == F_MFLO);
   endfunction

   // Expected output vector for a given position in the multiply timeline.
   function automatic logic [16:0] exp_vec(input int k);
      logic st, sh, hw, bz, stl;
      logic [5:0] op, cnt;
      st  = (k == 1);
      sh  = (k >= 2 && k <= MC + 1);
      hw  = (k == MC + 2);
      bz  = (k != 0);
      op  = hw ? 6'h3F : (bz ? 6'h19 : 6'h00);
      cnt = sh ? 6'(k - 2) : 6'd0;
      stl = bz && (is_mu() || is_rd());
      return {st, sh, hw, op, bz, stl, cnt};
   endfunction

   task automatic set_in(input bit v, input logic [1:0] op, input logic [5:0] fn,
                         input bit fl, input bit rs);
      IssueValid = v; ALUOp = op; Funct = fn; Flush = fl; Reset = rs;
   endtask

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      @(posedge Clk);
      if (Reset)                m_k = 0;
      else if (m_k == 0)        m_k = (is_mu() && !Flush) ? 1 : 0;
      else if (m_k == MC + 2)   m_k = 0;
      else if (Flush)           m_k = 0;
      else                      m_k = m_k + 1;
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 2'b00, 6'h00, 0, 1);
      tick(); tick();
      set_in(0, 2'b00, 6'h00, 0, 0);
   endtask

   task automatic start_multu();
      do_reset();
      set_in(1, 2'b10, F_MULTU, 0, 0);
      #1;
      total++;
      if (obs !== exp_vec(0)) begin
         bad++; $display("FAIL accept_cycle0 got=%h want=%h", obs, exp_vec(0));
      end
      tick();
      set_in(0, 2'b00, 6'h00, 0, 0);
   endtask

   task automatic test_reset();
      set_in(1, 2'b10, F_MULTU, 1, 1);
      tick(); tick(); tick();
      set_in(0, 2'b00, 6'h00, 0, 0);
      #1;
      total++;
      if (obs !== 17'h0) begin
         bad++; $display("FAIL reset_state got=%h want=%h", obs, 17'h0);
      end
      tick();
   endtask

   task automatic test_single();
      int h0, k;
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 36; c++) begin
         #1;
         k = (c <= MC + 2) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL single c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      total++;
      if (n_hilo - h0 !== 1) begin
         bad++; $display("FAIL single_hilo_count got=%0d want=1", n_hilo - h0);
      end
   endtask

   task automatic test_hazard_mfhi();
      int h0, k;
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 37; c++) begin
         if (c >= 5 && c <= 35) set_in(1, 2'b10, (c % 2) ? F_MFHI : F_MFLO, 0, 0);
         else                   set_in(0, 2'b00, 6'h00, 0, 0);
         #1;
         k = (c <= MC + 2) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL hazard c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
      total++;
      if (n_hilo - h0 !== 1) begin
         bad++; $display("FAIL hazard_hilo_count got=%0d want=1", n_hilo - h0);
      end
   endtask

   task automatic test_back_to_back();
      int h0, k;
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 71; c++) begin
         if (c >= 10 && c <= 35) set_in(1, 2'b10, F_MULTU, 0, 0);
         else                    set_in(0, 2'b00, 6'h00, 0, 0);
         #1;
         if (c <= MC + 2)                  k = c;
         else if (c == 35)                 k = 0;
         else if (c - 35 <= MC + 2)        k = c - 35;
         else                              k = 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL b2b c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      total++;
      if (n_hilo - h0 !== 2) begin
         bad++; $display("FAIL b2b_hilo_count got=%0d want=2", n_hilo - h0);
      end
   endtask

   task automatic test_flush();
      int h0, k;
      // Flush in RUN (cycle 20, Count 18) aborts the multiply.
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 40; c++) begin
         set_in(0, 2'b00, 6'h00, c == 20, 0);
         #1;
         k = (c <= 20) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL flush_run c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
      total++;
      if (n_hilo - h0 !== 0) begin
         bad++; $display("FAIL flush_run_hilo got=%0d want=0", n_hilo - h0);
      end
      // Flush in WRITE is ignored.
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 36; c++) begin
         set_in(0, 2'b00, 6'h00, c == MC + 2, 0);
         #1;
         k = (c <= MC + 2) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL flush_write c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
      total++;
      if (n_hilo - h0 !== 1) begin
         bad++; $display("FAIL flush_write_hilo got=%0d want=1", n_hilo - h0);
      end
      // Flush in IDLE blocks a same-cycle MULTU.
      do_reset();
      set_in(1, 2'b10, F_MULTU, 1, 0);
      tick();
      set_in(0, 2'b00, 6'h00, 0, 0);
      #1;
      total++;
      if (obs !== 17'h0) begin
         bad++; $display("FAIL flush_idle got=%h want=%h", obs, 17'h0);
      end
   endtask

   task automatic test_reset_mid();
      int h0, k;
      start_multu();
      h0 = n_hilo;
      for (int c = 1; c <= 40; c++) begin
         set_in(0, 2'b00, 6'h00, 0, c == 15);
         #1;
         k = (c <= 15) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL reset_mid c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
      total++;
      if (n_hilo - h0 !== 0) begin
         bad++; $display("FAIL reset_mid_hilo got=%0d want=0", n_hilo - h0);
      end
   endtask

   task automatic test_non_multu();
      int k;
      start_multu();
      for (int c = 1; c <= 36; c++) begin
         if (c >= 5 && c <= 12) set_in(1, 2'b10, (c % 2) ? F_ADD : F_SUB, 0, 0);
         else                   set_in(0, 2'b00, 6'h00, 0, 0);
         #1;
         k = (c <= MC + 2) ? c : 0;
         total++;
         if (obs !== exp_vec(k)) begin
            bad++; $display("FAIL alu_parallel c=%0d got=%h want=%h", c, obs, exp_vec(k));
         end
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         if (c < 4) set_in(1, 2'b00, F_MULTU, 0, 0);
         else       set_in(0, 2'b10, F_MULTU, 0, 0);
         #1;
         total++;
         if (obs !== 17'h0) begin
            bad++; $display("FAIL not_accepted c=%0d got=%h want=%h", c, obs, 17'h0);
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
   endtask

   task automatic test_random();
      logic [5:0] fn;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 6))
            0, 1:    fn = F_MULTU;
            2:       fn = F_MFHI;
            3:       fn = F_MFLO;
            4:       fn = F_ADD;
            5:       fn = F_SUB;
            default: fn = 6'($urandom);
         endcase
         set_in($urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom),
                fn,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 299) == 0);
         #1;
         total++;
         if (obs !== exp_vec(m_k)) begin
            bad++; $display("FAIL random i=%0d k=%0d got=%h want=%h", i, m_k, obs, exp_vec(m_k));
         end
         tick();
      end
      set_in(0, 2'b00, 6'h00, 0, 0);
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_hazard_mfhi();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_non_multu();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
